// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, reads one 16-bit word per request over a
// mem_rd/mem_ready handshake and strobes it into the instruction register.
module instruction_fetch #(
    parameter int unsigned            ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0,
    parameter logic [3:0]             HALT_OP  = 4'hF,
    parameter int unsigned            WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_data,
    output logic [15:0]       ir_data,
    output logic              ir_ls,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_LOAD,
        S_HALT
    } state_t;

    localparam logic [7:0] L_LAST_WAIT = 8'(WAIT_MAX - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [7:0]        r_cnt;
    logic              r_error;
    logic              w_timeout;

    // Timeout fires on the last permitted RD cycle that still has no ready.
    assign w_timeout = (r_state == S_RD) && !mem_ready && (r_cnt == L_LAST_WAIT);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!branch && start) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                if (mem_ready) begin
                    w_next = S_LOAD;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                w_next = (r_ir[15:12] == HALT_OP) ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_timeout;
            case (r_state)
                S_IDLE: begin
                    if (branch) begin
                        r_pc <= branch_addr;
                    end else if (start) begin
                        r_cnt <= '0;
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_ir <= mem_data;
                        r_pc <= r_pc + ADDR_W'(1);
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign ir_data  = r_ir;
    assign opcode   = r_ir[15:12];
    assign mem_rd   = (r_state == S_RD);
    assign ir_ls    = (r_state == S_LOAD);
    assign done     = (r_state == S_LOAD) && (r_ir[15:12] != HALT_OP);
    assign busy     = (r_state == S_RD) || (r_state == S_LOAD);
    assign halted   = (r_state == S_HALT);
    assign error    = r_error;

endmodule
